// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// Imported by the interface, the starvation counter and the arbiter top.
package dmem_arb_pkg;

    localparam int unsigned DEF_AW         = 7;
    localparam int unsigned DEF_DW         = 32;
    localparam int unsigned DEF_MEM_LAT    = 1;
    localparam int unsigned DEF_STARVE_MAX = 8;

    // Wide enough for the largest legal read latency (7).
    localparam int unsigned LAT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        REQ_PIPE,
        REQ_DMA
    } req_id_t;

    // The pipeline wins unless it is absent or the loader has waited too long.
    function automatic req_id_t pick_winner(input logic p_req, input logic d_req,
                                            input logic starved);
        return (d_req && (!p_req || starved)) ? REQ_DMA : REQ_PIPE;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of pipeline, loader and memory-side signals for the arbiter.
// slave is the arbiter's view; master is the view of the surrounding system.
interface dmem_port_arbiter_if #(
    parameter int unsigned AW = dmem_arb_pkg::DEF_AW,
    parameter int unsigned DW = dmem_arb_pkg::DEF_DW
);
    logic          p_req;
    logic          p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic [DW-1:0] p_rdata;
    logic          p_done;
    logic          p_stall;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_rdata, p_done, p_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_done,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_rdata, p_done, p_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_done,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );

endinterface

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Saturating count of pipeline grants taken while the loader was waiting.
// at_max tells the arbiter the loader must win the next arbitration.
module dmem_starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CW'(STARVE_MAX))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == CW'(STARVE_MAX));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Grants the single-port data memory to the pipeline or the debug/DMA loader,
// sequences one access at a time and returns a one-cycle done pulse.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic               CLK,
    input  logic               RSTn,
    dmem_port_arbiter_if.slave bus
);
    arb_state_t       state_q, state_d;
    req_id_t          win_q, win_d;
    req_id_t          winner;
    logic             we_q, we_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;

    logic             m_en_q, m_en_d;
    logic             m_we_q, m_we_d;
    logic [AW-1:0]    m_addr_q, m_addr_d;
    logic [DW-1:0]    m_wdata_q, m_wdata_d;

    logic [DW-1:0]    p_rdata_q, p_rdata_d;
    logic [DW-1:0]    d_rdata_q, d_rdata_d;
    logic             p_done_q, p_done_d;
    logic             d_done_q, d_done_d;

    logic             grant;
    logic             starve_inc, starve_clr, starve_at_max;

    dmem_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_at_max)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        we_d       = we_q;
        lat_cnt_d  = lat_cnt_q;
        m_en_d     = 1'b0;
        m_we_d     = 1'b0;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        p_rdata_d  = p_rdata_q;
        d_rdata_d  = d_rdata_q;
        p_done_d   = 1'b0;
        d_done_d   = 1'b0;
        grant      = 1'b0;
        winner     = pick_winner(bus.p_req, bus.d_req, starve_at_max);

        case (state_q)
            IDLE: begin
                if (bus.p_req || bus.d_req) begin
                    grant   = 1'b1;
                    win_d   = winner;
                    state_d = ISSUE;
                    m_en_d  = 1'b1;
                    if (winner == REQ_DMA) begin
                        we_d      = bus.d_we;
                        m_we_d    = bus.d_we;
                        m_addr_d  = bus.d_addr;
                        m_wdata_d = bus.d_wdata;
                    end else begin
                        we_d      = bus.p_we;
                        m_we_d    = bus.p_we;
                        m_addr_d  = bus.p_addr;
                        m_wdata_d = bus.p_wdata;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d  = RESP;
                    p_done_d = (win_q == REQ_PIPE);
                    d_done_d = (win_q == REQ_DMA);
                end else begin
                    state_d   = WAIT;
                    lat_cnt_d = LAT_W'(MEM_LAT - 1);
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d  = RESP;
                    p_done_d = (win_q == REQ_PIPE);
                    d_done_d = (win_q == REQ_DMA);
                    if (win_q == REQ_DMA) begin
                        d_rdata_d = bus.m_rdata;
                    end else begin
                        p_rdata_d = bus.m_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The loader's wait only grows when the pipeline beats a live loader request.
    assign starve_inc = grant && (winner == REQ_PIPE) && bus.d_req;
    assign starve_clr = grant && !starve_inc;

    // NOTE: reset is sampled on the clock edge (synchronous), so RSTn sits
    // inside the clocked branch rather than in the sensitivity list.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            win_q     <= REQ_PIPE;
            we_q      <= 1'b0;
            lat_cnt_q <= '0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            p_rdata_q <= '0;
            d_rdata_q <= '0;
            p_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop sees pre-edge values.
            state_q   <= state_d;
            win_q     <= win_d;
            we_q      <= we_d;
            lat_cnt_q <= lat_cnt_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            p_rdata_q <= p_rdata_d;
            d_rdata_q <= d_rdata_d;
            p_done_q  <= p_done_d;
            d_done_q  <= d_done_d;
        end
    end

    assign bus.m_en    = m_en_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.p_rdata = p_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.p_done  = p_done_q;
    assign bus.d_done  = d_done_q;
    assign bus.p_stall = bus.p_req & ~p_done_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench: instance a (MEM_LAT=1, STARVE_MAX=2) runs directed and
// random traffic against a transaction timeline model; instance b (MEM_LAT=4) covers latency and reset.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW     = 7;
    localparam int DW     = 32;
    localparam int LAT_A  = 1;
    localparam int SMAX_A = 2;
    localparam int LAT_B  = 4;
    localparam int SMAX_B = 8;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rstn_a, rstn_b;
    int   cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
    dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT_A), .STARVE_MAX(SMAX_A)) dut_a (
        .CLK (CLK), .RSTn (rstn_a), .bus (bus_a));
    dmem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT_B), .STARVE_MAX(SMAX_B)) dut_b (
        .CLK (CLK), .RSTn (rstn_b), .bus (bus_b));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 5) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(i * 257));
    endfunction

    // ---------------- memory models ----------------
    logic [DW-1:0] mem_a [128];
    logic [DW-1:0] mem_b [128];
    logic          mem_ready = 1'b0;
    int            rd_at_a = -1, rd_at_b = -1;
    logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0;

    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 128; i++) begin
                mem_a[i] <= init_word(i);
                mem_b[i] <= init_word(i);
            end
            mem_ready <= 1'b1;
        end else begin
            if (bus_a.m_en === 1'b1) begin
                if (bus_a.m_we) mem_a[bus_a.m_addr] <= bus_a.m_wdata;
                else begin rd_at_a <= cyc + LAT_A; rd_addr_a <= bus_a.m_addr; end
            end
            if (bus_b.m_en === 1'b1) begin
                if (bus_b.m_we) mem_b[bus_b.m_addr] <= bus_b.m_wdata;
                else begin rd_at_b <= cyc + LAT_B; rd_addr_b <= bus_b.m_addr; end
            end
        end
    end

    // Garbage outside the valid cycle exposes a mistimed capture.
    assign bus_a.m_rdata = (cyc == rd_at_a) ? mem_a[rd_addr_a] : (32'hBAD0_0000 ^ 32'(cyc));
    assign bus_b.m_rdata = (cyc == rd_at_b) ? mem_b[rd_addr_b] : (32'hBAD1_0000 ^ 32'(cyc));

    // ---------------- timeline reference model for instance a ----------------
    logic [DW-1:0] ref_mem [128];
    logic          mon_on = 1'b0;
    int            free_c = 0, en_c = -1, done_c = -1, starve = 0;
    logic          win = 1'b0, exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic          pd_exp, dd_exp;
    logic          prev_p_req = 1'b0, prev_d_req = 1'b0, prev_p_done = 1'b0, prev_d_done = 1'b0;
    int            grant_log [$];

    always @(negedge CLK) begin
        if (mon_on) begin
            pd_exp = (cyc == done_c) && !win;
            dd_exp = (cyc == done_c) && win;
            check("a_m_en", bus_a.m_en, cyc == en_c);
            if (cyc == en_c) begin
                check("a_m_we", bus_a.m_we, exp_we);
                check("a_m_addr", bus_a.m_addr, exp_addr);
                if (exp_we) check("a_m_wdata", bus_a.m_wdata, exp_wdata);
            end else begin
                check("a_m_we_off", bus_a.m_we, 1'b0);
            end
            check("a_p_done", bus_a.p_done, pd_exp);
            check("a_d_done", bus_a.d_done, dd_exp);
            check("a_p_stall", bus_a.p_stall, bus_a.p_req && !pd_exp);
            if (bus_a.p_done) grant_log.push_back(0);
            if (bus_a.d_done) grant_log.push_back(1);
            if (prev_p_req && !bus_a.p_req) check("a_p_req_drop", prev_p_done, 1'b1);
            if (prev_d_req && !bus_a.d_req) check("a_d_req_drop", prev_d_done, 1'b1);

            // Arbiter is free to sample requests from free_c onward.
            if (cyc >= free_c && (bus_a.p_req || bus_a.d_req)) begin
                win = bus_a.d_req && (!bus_a.p_req || starve == SMAX_A);
                if (!win && bus_a.d_req) starve = (starve < SMAX_A) ? starve + 1 : SMAX_A;
                else starve = 0;
                exp_we    = win ? bus_a.d_we    : bus_a.p_we;
                exp_addr  = win ? bus_a.d_addr  : bus_a.p_addr;
                exp_wdata = win ? bus_a.d_wdata : bus_a.p_wdata;
                en_c   = cyc + 1;
                done_c = cyc + 1 + (exp_we ? 1 : 1 + LAT_A);
                free_c = done_c + 1;
            end
            prev_p_req  = bus_a.p_req;
            prev_d_req  = bus_a.d_req;
            prev_p_done = bus_a.p_done;
            prev_d_done = bus_a.d_done;
        end
    end

    // ---------------- requester tasks ----------------
    task automatic pipe_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           output logic [DW-1:0] rd, output int dc);
        bus_a.p_we = we; bus_a.p_addr = addr; bus_a.p_wdata = wd; bus_a.p_req = 1'b1;
        dc = -1; rd = '0;
        for (int k = 0; k < 200 && dc < 0; k++) begin
            @(negedge CLK);
            if (bus_a.p_done) begin dc = cyc; rd = bus_a.p_rdata; end
        end
        if (dc < 0) check("a_p_timeout", 0, 1);
        else if (!we) check("a_p_rdata", rd, ref_mem[addr]);
        else ref_mem[addr] = wd;
        @(posedge CLK); #1;
        bus_a.p_req = 1'b0;
    endtask

    task automatic dma_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd, output int dc);
        bus_a.d_we = we; bus_a.d_addr = addr; bus_a.d_wdata = wd; bus_a.d_req = 1'b1;
        dc = -1; rd = '0;
        for (int k = 0; k < 200 && dc < 0; k++) begin
            @(negedge CLK);
            if (bus_a.d_done) begin dc = cyc; rd = bus_a.d_rdata; end
        end
        if (dc < 0) check("a_d_timeout", 0, 1);
        else if (!we) check("a_d_rdata", rd, ref_mem[addr]);
        else ref_mem[addr] = wd;
        @(posedge CLK); #1;
        bus_a.d_req = 1'b0;
    endtask

    task automatic b_read(input logic [AW-1:0] addr, output int en_first, output int en_cnt,
                          output int dc, output logic [DW-1:0] rd);
        bus_b.p_we = 1'b0; bus_b.p_addr = addr; bus_b.p_wdata = '0; bus_b.p_req = 1'b1;
        en_first = -1; en_cnt = 0; dc = -1; rd = '0;
        for (int k = 0; k < 20 && dc < 0; k++) begin
            @(negedge CLK);
            if (bus_b.m_en) begin en_cnt++; if (en_first < 0) en_first = cyc; end
            if (bus_b.p_done) begin dc = cyc; rd = bus_b.p_rdata; end
        end
        if (dc < 0) check("b_timeout", 0, 1);
        @(posedge CLK); #1;
        bus_b.p_req = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench did not finish");
    end

    // ---------------- main sequence ----------------
    logic [DW-1:0] rd0, rd1, rd2, rd_p, rd_d;
    int            t, dc0, dc1, dc2, dc_p, dc_d, en_f, en_n, stray;
    int            exp_order [6] = '{0, 0, 1, 0, 0, 1};

    initial begin
        rstn_a = 1'b0; rstn_b = 1'b0;
        bus_a.p_req = 0; bus_a.p_we = 0; bus_a.p_addr = '0; bus_a.p_wdata = '0;
        bus_a.d_req = 0; bus_a.d_we = 0; bus_a.d_addr = '0; bus_a.d_wdata = '0;
        bus_b.p_req = 0; bus_b.p_we = 0; bus_b.p_addr = '0; bus_b.p_wdata = '0;
        bus_b.d_req = 0; bus_b.d_we = 0; bus_b.d_addr = '0; bus_b.d_wdata = '0;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_m_en",    {bus_a.m_en, bus_b.m_en}, 2'b00);
        check("rst_m_we",    {bus_a.m_we, bus_b.m_we}, 2'b00);
        check("rst_done",    {bus_a.p_done, bus_a.d_done, bus_b.p_done, bus_b.d_done}, 4'b0);
        check("rst_m_addr",  {bus_a.m_addr, bus_b.m_addr}, '0);
        check("rst_m_wdata", {bus_a.m_wdata, bus_b.m_wdata}, '0);
        check("rst_rdata_a", {bus_a.p_rdata, bus_a.d_rdata}, '0);
        check("rst_rdata_b", {bus_b.p_rdata, bus_b.d_rdata}, '0);
        @(posedge CLK); #1;
        rstn_a = 1'b1; rstn_b = 1'b1;
        mon_on = 1'b1;

        // Pipeline read alone.
        t = cyc;
        pipe_op(1'b0, 7'd5, '0, rd0, dc0);
        check("t1_done_lat", dc0 - t, 3);
        check("t1_rdata", rd0, 32'hDEADBEEF);

        // Loader write alone, then pipeline reads it back.
        t = cyc;
        dma_op(1'b1, 7'd9, 32'h0000_1234, rd0, dc0);
        check("t2_done_lat", dc0 - t, 2);
        pipe_op(1'b0, 7'd9, '0, rd0, dc0);
        check("t2_readback", rd0, 32'h0000_1234);

        // Simultaneous requests: pipeline first, loader re-sampled afterwards.
        t = cyc;
        fork
            pipe_op(1'b0, 7'd3, '0, rd1, dc1);
            dma_op(1'b0, 7'd7, '0, rd2, dc2);
        join
        check("t3_pipe_lat", dc1 - t, 3);
        check("t3_dma_lat", dc2 - t, 7);

        // Starvation guard with continuous requests from both sides.
        grant_log.delete();
        fork
            begin : starve_pipe
                for (int i = 0; i < 4; i++) pipe_op(1'(i & 1), 7'(i + 16), 32'(i * 3 + 1), rd_p, dc_p);
            end
            begin : starve_dma
                for (int i = 0; i < 2; i++) dma_op(1'b0, 7'(i + 16), '0, rd_d, dc_d);
            end
        join
        check("t4_grant_cnt", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check($sformatf("t4_grant_%0d", i), grant_log[i], exp_order[i]);

        // Random traffic from both requesters.
        fork
            begin : rand_pipe
                int gap;
                for (int i = 0; i < 40; i++) begin
                    gap = $urandom_range(0, 3);
                    if (gap > 0) begin repeat (gap) @(posedge CLK); #1; end
                    pipe_op(1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), $urandom, rd_p, dc_p);
                end
            end
            begin : rand_dma
                int gap;
                for (int i = 0; i < 40; i++) begin
                    gap = $urandom_range(0, 4);
                    if (gap > 0) begin repeat (gap) @(posedge CLK); #1; end
                    dma_op(1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), $urandom, rd_d, dc_d);
                end
            end
        join

        // Instance b: MEM_LAT=4 latency and single m_en strobe.
        @(posedge CLK); #1;
        t = cyc;
        b_read(7'd20, en_f, en_n, dc0, rd0);
        check("b_en_at", en_f - t, 1);
        check("b_en_cnt", en_n, 1);
        check("b_done_lat", dc0 - t, 6);
        check("b_rdata", rd0, init_word(20));

        // Reset while the read sits in WAIT.
        t = cyc;
        bus_b.p_we = 1'b0; bus_b.p_addr = 7'd21; bus_b.p_req = 1'b1;
        repeat (3) @(posedge CLK); #1;
        rstn_b = 1'b0; bus_b.p_req = 1'b0;
        @(posedge CLK); #1;
        rstn_b = 1'b1;
        @(negedge CLK);
        check("b_rst_m_en", bus_b.m_en, 1'b0);
        check("b_rst_done", bus_b.p_done, 1'b0);
        check("b_rst_rdata", bus_b.p_rdata, '0);
        stray = 0;
        repeat (8) begin
            @(negedge CLK);
            if (bus_b.p_done || bus_b.d_done || bus_b.m_en) stray++;
        end
        check("b_rst_no_done", stray, 0);
        @(posedge CLK); #1;
        t = cyc;
        b_read(7'd22, en_f, en_n, dc0, rd0);
        check("b_post_rst_en", en_f - t, 1);
        check("b_post_rst_lat", dc0 - t, 6);
        check("b_post_rst_rdata", rd0, init_word(22));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Sequential arbiter and access sequencer for the single-port 128-word data memory of the pipelined MIPS core. Two requesters share the memory: the pipeline's Memory stage (load/store) and a debug/DMA loader that preloads or inspects data memory. The block grants one access at a time and drives the memory enable, write and address lines for the granted access. It stalls the pipeline while its access is pending, and a starvation guard guarantees the loader forward progress.

## Interface
- AW, 7, word-address width (128 locations)
- DW, 32, data width
- MEM_LAT, 1, memory read latency in cycles from m_en to valid m_rdata; legal range 1..7
- STARVE_MAX, 8, consecutive pipeline grants tolerated while loader waits; legal range 1..255

- CLK  in  1  clock, all state on rising edge
- RSTn  in  1  reset, synchronous, active-low
- p_req  in  1  pipeline access request, held until p_done
- p_we  in  1  pipeline write (sw) when 1, read (lw) when 0
- p_addr  in  AW  pipeline word address
- p_wdata  in  DW  pipeline store data
- p_rdata  out  DW  pipeline load data, valid while p_done=1
- p_done  out  1  one-cycle completion pulse to pipeline
- p_stall  out  1  pipeline must hold Memory stage; = p_req & !p_done
- d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  loader request bundle, same rules as pipeline
- d_rdata  out  DW  loader read data, valid while d_done=1
- d_done  out  1  one-cycle completion pulse to loader
- m_en  out  1  memory access strobe, one cycle per access
- m_we  out  1  memory write enable, qualified by m_en
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid MEM_LAT cycles after m_en

## Operation
- Request rule: a requester raises req with stable we/addr/wdata and holds all of them until its done pulse. It may drop req or present a new request in the cycle after done. Dropping req before done is illegal; the bench asserts on it.
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, latch the winner's id/we/addr/wdata and go to ISSUE. Otherwise stay in IDLE.
- Winner selection: the pipeline wins. Exception: the loader wins when d_req=1 and starve_cnt==STARVE_MAX. A lone requester always wins.
- ISSUE: m_en=1, with m_we/m_addr/m_wdata driven from latched values. Writes go to RESP; reads go to WAIT with lat_cnt=MEM_LAT-1.
- WAIT: decrement lat_cnt. When lat_cnt==0, capture m_rdata into the winner's rdata register and go to RESP.
- RESP: pulse the winner's done for one cycle, then go to IDLE.
- starve_cnt update, on each IDLE→ISSUE transition:
  - pipeline granted while d_req=1: increment, saturating at STARVE_MAX
  - loader granted: clear to 0
  - otherwise d_req=0: clear to 0
- The loser of an arbitration keeps its req high and is re-evaluated in the next IDLE cycle.
- m_en=0 and m_we=0 in every state except ISSUE. m_addr/m_wdata hold their last values.
- p_rdata/d_rdata hold their last captured value outside RESP.

## Timing
- Reset values: FSM=IDLE, starve_cnt=0, lat_cnt=0, all done=0, m_en=0, m_we=0, m_addr=0, m_wdata=0, p_rdata=0, d_rdata=0.
- Latency, with req sampled in IDLE at cycle T:
  - m_en at T+1
  - read: m_rdata sampled at end of T+1+MEM_LAT, done at T+2+MEM_LAT
  - write: memory written at end of T+1, done at T+2
- Throughput: one read per MEM_LAT+3 cycles, one write per 3 cycles. A held req after done is re-sampled in the following IDLE cycle.
- p_stall is combinational from p_req and registered p_done; it is high from the req cycle through the cycle before done.
- Simultaneous req in IDLE: exactly one grant, following the winner-selection rule. No request is lost.
- Reset mid-operation: RSTn low for one edge returns to IDLE with reset values. The in-flight read result is discarded and no done pulse is emitted.
- Request arriving during RESP is not sampled until the next IDLE.

## Structure
- Package dmem_arb_pkg:
  - arb_state_t enum (IDLE, ISSUE, WAIT, RESP)
  - req_id_t enum (REQ_PIPE, REQ_DMA)
  - default AW/DW constants
- Sub-module dmem_starve_counter: saturating counter with inc/clr inputs, width $clog2(STARVE_MAX+1), flag at_max.
- FSM, latching and output registers live in the top module.

## Test plan
- Pipeline read alone, MEM_LAT=1, memory word 5=0xDEADBEEF: p_req/p_addr=5 at T gives m_en at T+1, p_done with p_rdata=0xDEADBEEF at T+3, p_stall high T..T+2.
- Loader write alone, d_addr=9, d_wdata=0x1234: m_en=m_we=1 with m_addr=9 at T+1, d_done at T+2, and a subsequent pipeline read of address 9 returns 0x1234.
- Both requests at T: pipeline served first (p_done at T+3). Loader, still holding req, is sampled in IDLE at T+4 and gets d_done at T+7.
- Starvation, STARVE_MAX=2: continuous p_req and d_req. Grant order is pipe, pipe, dma, pipe, pipe, dma, and starve_cnt returns to 0 after each dma grant.
- Reset mid-read, MEM_LAT=3: RSTn low during WAIT. No done pulse, m_en=0 and state IDLE next cycle, and a fresh p_req completes normally.
- MEM_LAT=4 read: done occurs exactly 6 cycles after the req sample cycle, and m_en is high for exactly one cycle.
